// File: rtl/rotate_seq.sv
// Sequential rotator/shifter: moves a WIDTH-bit word one position per clock under a start/busy/done handshake.
// Optional: define ROTATE_SEQ_CARRY_EN to add carry_out, which holds the last bit moved out of the word.
module rotate_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amt,
  input  logic             d,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] r,
  output logic             busy,
`ifdef ROTATE_SEQ_CARRY_EN
  output logic             carry_out,
`endif
  output logic             done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [AMT_W-1:0] r_count;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic             r_done;
  logic [WIDTH-1:0] w_next;

  // One-position move of the working word; mode 11 falls through to rotate.
  always_comb begin
    w_next = r_word;
    if (r_dir) begin
      case (r_mode)
        2'b01, 2'b10: w_next = {r_word[WIDTH-2:0], 1'b0};
        default:      w_next = {r_word[WIDTH-2:0], r_word[WIDTH-1]};
      endcase
    end else begin
      case (r_mode)
        2'b01:   w_next = {1'b0, r_word[WIDTH-1:1]};
        2'b10:   w_next = {r_word[WIDTH-1], r_word[WIDTH-1:1]};
        default: w_next = {r_word[0], r_word[WIDTH-1:1]};
      endcase
    end
  end

`ifdef ROTATE_SEQ_CARRY_EN
  logic r_carry;
  logic w_carry;

  assign w_carry   = r_dir ? r_word[WIDTH-1] : r_word[0];
  assign carry_out = r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_carry <= 1'b0;
    end else if (r_state == BUSY) begin
      r_carry <= w_carry;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 2'b00;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_word  <= in;
            r_count <= amt;
            r_dir   <= d;
            r_mode  <= mode;
            if (amt == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_word  <= w_next;
          r_count <= r_count - 1'b1;
          // Final step: the count reaches zero on this edge.
          if (r_count == AMT_W'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign r    = r_word;
  assign busy = (r_state != IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_rotate_seq.sv
// Scoreboard bench for rotate_seq: stimulus pushes expected results, a negedge monitor pops them on done.
module tb_rotate_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_w;
  logic [2:0] amt;
  logic       d;
  logic [1:0] mode;
  logic [7:0] r;
  logic       busy;
  logic       done;
`ifdef ROTATE_SEQ_CARRY_EN
  logic       carry_out;
`endif

  rotate_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in        (in_w),
    .amt       (amt),
    .d         (d),
    .mode      (mode),
    .r         (r),
    .busy      (busy),
`ifdef ROTATE_SEQ_CARRY_EN
    .carry_out (carry_out),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c;
    int         cyc;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   cyc    = 0;
  int   checks = 0;
  int   errs   = 0;
  int   dones  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      dones++;
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done actual r=%h required no done", r);
      end else begin
        e_mon = q.pop_front();
        chk({e_mon.name, "_r"}, 32'(r), 32'(e_mon.r));
        chk({e_mon.name, "_cycle"}, 32'(cyc), 32'(e_mon.cyc));
        chk({e_mon.name, "_busy"}, 32'(busy), 32'd1);
`ifdef ROTATE_SEQ_CARRY_EN
        chk({e_mon.name, "_carry"}, 32'(carry_out), 32'(e_mon.c));
`endif
        $display("txn %s: r=%h at cycle %0d (expected r=%h at cycle %0d)", e_mon.name, r, cyc, e_mon.r, e_mon.cyc);
      end
    end
  end

  // Drives one start pulse and pushes the expected result; returns at the negedge after the start edge.
  task automatic issue(input string nm, input logic [7:0] vi, input logic [2:0] va, input logic vd,
                       input logic [1:0] vm, input logic [7:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    in_w  = vi;
    amt   = va;
    d     = vd;
    mode  = vm;
    start = 1'b1;
    e.r    = er;
    e.c    = ec;
    e.cyc  = cyc + 1 + int'(va);
    e.name = nm;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in_w  = ~vi;
    amt   = ~va;
    d     = ~vd;
    mode  = vm ^ 2'b01;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL done_timeout actual pending=%0d required pending=0", q.size());
      q.delete();
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_w  = 8'h00;
    amt   = 3'd0;
    d     = 1'b0;
    mode  = 2'b00;
    #12;
    chk("reset_r", 32'(r), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Rotate right C3 by 2, with the intermediate step observed.
    issue("rotr_c3", 8'hC3, 3'd2, 1'b0, 2'b00, 8'hF0, 1'b1);
    chk("rotr_busy_next", 32'(busy), 32'd1);
    chk("rotr_load", 32'(r), 32'hC3);
    @(negedge clk);
    chk("rotr_step1", 32'(r), 32'hE1);
    wait_done();

    issue("rotl_96", 8'h96, 3'd3, 1'b1, 2'b00, 8'hB4, 1'b0);
    wait_done();
    issue("lsl_81", 8'h81, 3'd1, 1'b1, 2'b01, 8'h02, 1'b1);
    wait_done();
    issue("asr_90", 8'h90, 3'd3, 1'b0, 2'b10, 8'hF2, 1'b0);
    wait_done();
    issue("lsr_90", 8'h90, 3'd3, 1'b0, 2'b01, 8'h12, 1'b0);
    wait_done();
    chk("hold_after_done", 32'(r), 32'h12);

    // Zero amount: done right after the load edge, busy for that cycle only.
    issue("zero_a5", 8'hA5, 3'd0, 1'b0, 2'b00, 8'hA5, 1'b0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("zero_busy_after", 32'(busy), 32'd0);
    chk("zero_done_after", 32'(done), 32'd0);
    wait_done();

    // A second start while busy must be ignored.
    issue("busyign_01", 8'h01, 3'd7, 1'b1, 2'b00, 8'h80, 1'b0);
    repeat (2) @(negedge clk);
    in_w  = 8'hFF;
    amt   = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of an operation.
    issue("abort_0f", 8'h0F, 3'd7, 1'b0, 2'b00, 8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_r", 32'(r), 32'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    issue("post_rst_0f", 8'h0F, 3'd4, 1'b0, 2'b00, 8'hF0, 1'b1);
    wait_done();

    chk("done_count", 32'(dones), 32'd8);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
